pg_retention_agent: RTL and testbench

Block-side endpoint of the power-gating save/restore handshake. It answers the controller's save_state and restore_state requests with ack_to_ctrl. On save, it copies NUM_WORDS words of live block state into always-on retention storage. On restore, it writes those words back once power is re-applied. It sits inside the gated block's always-on shell, between the power-gating controller and the block's state register file.

---
 rtl/pg_pkg.sv | 34 +++
 rtl/pg_retention_mem.sv | 40 ++++
 rtl/pg_retention_agent.sv | 267 ++++++++++++++++++++++++++
 tb/tb_pg_retention_agent.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pg_pkg
//  Description : Shared types and handshake constants for the power-gating
//                retention agent (FSM state encoding, ack / clock-enable
//                levels, request-conflict helper).
//  Revision    : 1.0 - initial release
// ============================================================================
package pg_pkg;

    // Agent FSM states, 3-bit explicit encoding.
    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        WAIT_IDLE   = 3'd1,
        SAVE        = 3'd2,
        SAVE_ACK    = 3'd3,
        RETAINED    = 3'd4,
        RESTORE     = 3'd5,
        RESTORE_ACK = 3'd6
    } pg_state_e;

    // Handshake / clock-enable levels.
    localparam logic c_ACK_ON   = 1'b1;
    localparam logic c_ACK_OFF  = 1'b0;
    localparam logic c_CLK_RUN  = 1'b1;
    localparam logic c_CLK_STOP = 1'b0;

    // Save and restore requested together is a controller protocol error.
    function automatic logic req_conflict(input logic save_req, input logic restore_req);
        return save_req & restore_req;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pg_retention_mem.sv
`default_nettype none
// ============================================================================
//  Module      : pg_retention_mem
//  Description : Always-on retention storage, NUM_WORDS x DATA_W.
//                One synchronous write port, one asynchronous read port.
//                Deliberately not reset: contents are qualified by the
//                agent's saved_valid flag.
//  Ports       : clk      - always-on clock
//                wr_en    - write strobe
//                wr_idx   - write word index
//                wr_data  - write data
//                rd_idx   - read word index
//                rd_data  - read data (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module pg_retention_mem #(
    parameter int NUM_WORDS = 8,
    parameter int DATA_W    = 32,
    parameter int IDX_W     = $clog2(NUM_WORDS)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] r_mem [NUM_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_idx];

endmodule
`default_nettype wire

// File: rtl/pg_retention_agent.sv
`default_nettype none
// ============================================================================
//  Module      : pg_retention_agent
//  Description : Block-side endpoint of the power-gating save/restore
//                handshake. Copies NUM_WORDS live state words into always-on
//                retention storage on save_state and writes them back on
//                restore_state, answering each with a 4-phase ack_to_ctrl.
//  Ports       : clk, rst          - always-on clock, sync active-high reset
//                save_state        - controller save request (level)
//                restore_state     - controller restore request (level)
//                power_switch_en   - block rail enabled
//                block_busy        - block still draining work
//                ack_to_ctrl       - 4-phase acknowledge
//                live_rd_idx/data  - read port into block state file
//                live_wr_en/idx/data - write port into block state file
//                clk_gate_en       - block functional clock enable
//                saved_valid       - retention storage holds a full snapshot
//                retention_err     - sticky protocol / abort error
//  Revision    : 1.0 - initial release
// ============================================================================
module pg_retention_agent
    import pg_pkg::*;
#(
    parameter int NUM_WORDS = 8,
    parameter int DATA_W    = 32,
    parameter int IDX_W     = $clog2(NUM_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              save_state,
    input  logic              restore_state,
    input  logic              power_switch_en,
    input  logic              block_busy,
    output logic              ack_to_ctrl,
    output logic [IDX_W-1:0]  live_rd_idx,
    input  logic [DATA_W-1:0] live_rd_data,
    output logic              live_wr_en,
    output logic [IDX_W-1:0]  live_wr_idx,
    output logic [DATA_W-1:0] live_wr_data,
    output logic              clk_gate_en,
    output logic              saved_valid,
    output logic              retention_err
);

    localparam logic [IDX_W:0] c_LAST = (IDX_W+1)'(NUM_WORDS - 1);
    localparam logic [IDX_W:0] c_ONE  = (IDX_W+1)'(1);

    // ------------------------------------------------------------------
    // Registered state and outputs
    // ------------------------------------------------------------------
    pg_state_e         r_state;
    logic [IDX_W:0]    r_cnt;
    logic              r_ack;
    logic [IDX_W-1:0]  r_rd_idx;
    logic              r_wr_en;
    logic [IDX_W-1:0]  r_wr_idx;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_clk_gate_en;
    logic              r_saved_valid;
    logic              r_err;

    // Next-state values
    pg_state_e         w_state_nxt;
    logic [IDX_W:0]    w_cnt_nxt;
    logic              w_ack_nxt;
    logic [IDX_W-1:0]  w_rd_idx_nxt;
    logic              w_wr_en_nxt;
    logic [IDX_W-1:0]  w_wr_idx_nxt;
    logic [DATA_W-1:0] w_wr_data_nxt;
    logic              w_clk_gate_en_nxt;
    logic              w_saved_valid_nxt;
    logic              w_err_nxt;

    logic [IDX_W:0]    w_cnt_inc;
    logic              w_last;
    logic              w_conflict;
    logic              w_mem_we;
    logic [IDX_W-1:0]  w_mem_rd_idx;
    logic [DATA_W-1:0] w_mem_rd_data;

    assign w_cnt_inc  = r_cnt + c_ONE;
    assign w_last     = (r_cnt == c_LAST);
    assign w_conflict = req_conflict(save_state, restore_state);

    // Capture happens in the same cycle live_rd_idx presents word r_cnt;
    // a dropping rail aborts, so the partial word is not captured.
    assign w_mem_we = (r_state == SAVE) && power_switch_en;

    // During restore the output registers are loaded one word ahead, so the
    // storage is read at the index that becomes current on the next edge.
    // From RETAINED the first word (index 0) is fetched.
    assign w_mem_rd_idx = (r_state == RESTORE) ? w_cnt_inc[IDX_W-1:0] : '0;

    pg_retention_mem #(
        .NUM_WORDS (NUM_WORDS),
        .DATA_W    (DATA_W),
        .IDX_W     (IDX_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (w_mem_we),
        .wr_idx  (r_cnt[IDX_W-1:0]),
        .wr_data (live_rd_data),
        .rd_idx  (w_mem_rd_idx),
        .rd_data (w_mem_rd_data)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_ack         <= c_ACK_OFF;
            r_rd_idx      <= '0;
            r_wr_en       <= 1'b0;
            r_wr_idx      <= '0;
            r_wr_data     <= '0;
            r_clk_gate_en <= c_CLK_RUN;
            r_saved_valid <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_ack         <= w_ack_nxt;
            r_rd_idx      <= w_rd_idx_nxt;
            r_wr_en       <= w_wr_en_nxt;
            r_wr_idx      <= w_wr_idx_nxt;
            r_wr_data     <= w_wr_data_nxt;
            r_clk_gate_en <= w_clk_gate_en_nxt;
            r_saved_valid <= w_saved_valid_nxt;
            r_err         <= w_err_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_ack_nxt         = r_ack;
        w_rd_idx_nxt      = r_rd_idx;
        w_wr_en_nxt       = r_wr_en;
        w_wr_idx_nxt      = r_wr_idx;
        w_wr_data_nxt     = r_wr_data;
        w_clk_gate_en_nxt = r_clk_gate_en;
        w_saved_valid_nxt = r_saved_valid;
        w_err_nxt         = r_err;

        case (r_state)
            IDLE: begin
                if (r_ack) begin
                    // Finishing a write-less restore handshake; nothing new
                    // is accepted until the controller drops its request.
                    if (!restore_state) begin
                        w_ack_nxt = c_ACK_OFF;
                    end
                end else if (w_conflict) begin
                    w_err_nxt = 1'b1;
                end else if (save_state) begin
                    w_state_nxt       = WAIT_IDLE;
                    w_clk_gate_en_nxt = c_CLK_STOP;
                end else if (restore_state) begin
                    // Power was never removed: live state is still intact,
                    // so acknowledge without writing. Without a snapshot this
                    // is a controller error.
                    w_ack_nxt = c_ACK_ON;
                    if (!r_saved_valid) begin
                        w_err_nxt = 1'b1;
                    end
                end
            end

            WAIT_IDLE: begin
                if (!save_state) begin
                    w_state_nxt       = IDLE;
                    w_clk_gate_en_nxt = c_CLK_RUN;
                end else if (!block_busy) begin
                    w_state_nxt       = SAVE;
                    w_cnt_nxt         = '0;
                    w_rd_idx_nxt      = '0;
                    // The old snapshot is overwritten from here on.
                    w_saved_valid_nxt = 1'b0;
                end
            end

            SAVE: begin
                if (!power_switch_en) begin
                    w_state_nxt       = RETAINED;
                    w_saved_valid_nxt = 1'b0;
                    w_err_nxt         = 1'b1;
                end else if (w_last) begin
                    w_state_nxt       = SAVE_ACK;
                    w_saved_valid_nxt = 1'b1;
                end else begin
                    w_cnt_nxt    = w_cnt_inc;
                    w_rd_idx_nxt = w_cnt_inc[IDX_W-1:0];
                end
            end

            SAVE_ACK: begin
                if (!r_ack) begin
                    w_ack_nxt = c_ACK_ON;
                end else if (!save_state) begin
                    w_ack_nxt   = c_ACK_OFF;
                    w_state_nxt = RETAINED;
                end
            end

            RETAINED: begin
                if (w_conflict) begin
                    w_err_nxt = 1'b1;
                end else if (restore_state && power_switch_en) begin
                    // Load word 0 now so the first write strobe is visible
                    // in the first RESTORE cycle.
                    w_state_nxt   = RESTORE;
                    w_cnt_nxt     = '0;
                    w_wr_en_nxt   = 1'b1;
                    w_wr_idx_nxt  = '0;
                    w_wr_data_nxt = w_mem_rd_data;
                end
            end

            RESTORE: begin
                if (!power_switch_en) begin
                    // Snapshot is untouched, so the restore may be retried.
                    w_state_nxt = RETAINED;
                    w_wr_en_nxt = 1'b0;
                    w_err_nxt   = 1'b1;
                end else if (w_last) begin
                    w_state_nxt = RESTORE_ACK;
                    w_wr_en_nxt = 1'b0;
                end else begin
                    w_cnt_nxt     = w_cnt_inc;
                    w_wr_idx_nxt  = w_cnt_inc[IDX_W-1:0];
                    w_wr_data_nxt = w_mem_rd_data;
                end
            end

            RESTORE_ACK: begin
                if (!r_ack) begin
                    w_ack_nxt         = c_ACK_ON;
                    w_clk_gate_en_nxt = c_CLK_RUN;
                end else if (!restore_state) begin
                    w_ack_nxt   = c_ACK_OFF;
                    w_state_nxt = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign ack_to_ctrl   = r_ack;
    assign live_rd_idx   = r_rd_idx;
    assign live_wr_en    = r_wr_en;
    assign live_wr_idx   = r_wr_idx;
    assign live_wr_data  = r_wr_data;
    assign clk_gate_en   = r_clk_gate_en;
    assign saved_valid   = r_saved_valid;
    assign retention_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pg_retention_agent.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pg_retention_agent
//  Description : Directed self-checking bench for pg_retention_agent.
//                Expected restore writes are queued when a restore is
//                requested and popped whenever the DUT strobes live_wr_en.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pg_retention_agent;
    import pg_pkg::*;

    localparam int NW = 8;
    localparam int DW = 32;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          save_state;
    logic          restore_state;
    logic          power_switch_en;
    logic          block_busy;
    logic          ack_to_ctrl;
    logic [IW-1:0] live_rd_idx;
    logic [DW-1:0] live_rd_data;
    logic          live_wr_en;
    logic [IW-1:0] live_wr_idx;
    logic [DW-1:0] live_wr_data;
    logic          clk_gate_en;
    logic          saved_valid;
    logic          retention_err;

    logic [DW-1:0] live_mem [NW];
    assign live_rd_data = live_mem[live_rd_idx];

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    pg_retention_agent #(
        .NUM_WORDS (NW),
        .DATA_W    (DW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .save_state      (save_state),
        .restore_state   (restore_state),
        .power_switch_en (power_switch_en),
        .block_busy      (block_busy),
        .ack_to_ctrl     (ack_to_ctrl),
        .live_rd_idx     (live_rd_idx),
        .live_rd_data    (live_rd_data),
        .live_wr_en      (live_wr_en),
        .live_wr_idx     (live_wr_idx),
        .live_wr_data    (live_wr_data),
        .clk_gate_en     (clk_gate_en),
        .saved_valid     (saved_valid),
        .retention_err   (retention_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample 1 ns later, and score any write strobe.
    task automatic tick();
        wr_t e;
        @(posedge clk);
        #1;
        if (live_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("wr_unexpected", 64'(live_wr_en), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_idx", 64'(live_wr_idx), 64'(e.idx));
                chk("wr_data", 64'(live_wr_data), 64'(e.data));
            end
        end
    endtask

    task automatic fill_live(input logic [DW-1:0] base);
        for (int i = 0; i < NW; i++) live_mem[i] = base + DW'(i);
    endtask

    task automatic push_restore(input logic [DW-1:0] base, input int count);
        wr_t e;
        for (int i = 0; i < count; i++) begin
            e.idx  = IW'(i);
            e.data = base + DW'(i);
            exp_q.push_back(e);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ack"},   64'(ack_to_ctrl),   64'd0);
        chk({tag, "_wren"},  64'(live_wr_en),    64'd0);
        chk({tag, "_sv"},    64'(saved_valid),   64'd0);
        chk({tag, "_err"},   64'(retention_err), 64'd0);
        chk({tag, "_rdidx"}, 64'(live_rd_idx),   64'd0);
        chk({tag, "_wridx"}, 64'(live_wr_idx),   64'd0);
        chk({tag, "_wrdat"}, 64'(live_wr_data),  64'd0);
        chk({tag, "_cg"},    64'(clk_gate_en),   64'd1);
        chk({tag, "_state"}, 64'(dut.r_state),   64'(IDLE));
    endtask

    task automatic do_reset();
        rst = 1'b1; save_state = 1'b0; restore_state = 1'b0;
        power_switch_en = 1'b1; block_busy = 1'b0;
        tick(); tick();
        rst = 1'b0;
        exp_q.delete();
    endtask

    // Save from IDLE with block_busy low; checks latency and read sweep.
    task automatic do_save(input logic [DW-1:0] base, input string tag);
        int n;
        logic [IW-1:0] seen[$];
        fill_live(base);
        save_state = 1'b1;
        n = 0;
        do begin
            tick(); n++;
            seen.push_back(live_rd_idx);
        end while (ack_to_ctrl !== 1'b1 && n < 30);
        chk({tag, "_ack_lat"}, 64'(n - 1), 64'(NW + 2));
        if (seen.size() >= NW + 1) begin
            for (int i = 0; i < NW; i++) chk({tag, "_rd_sweep"}, 64'(seen[i+1]), 64'(i));
        end
        chk({tag, "_sv"}, 64'(saved_valid), 64'd1);
        chk({tag, "_cg"}, 64'(clk_gate_en), 64'd0);
        save_state = 1'b0;
        tick();
        chk({tag, "_ack_drop"}, 64'(ack_to_ctrl), 64'd0);
        tick();
        chk({tag, "_state"}, 64'(dut.r_state), 64'(RETAINED));
    endtask

    // Restore from RETAINED; all expected writes must be consumed by the ack.
    task automatic do_restore(input logic [DW-1:0] base, input string tag);
        int n;
        push_restore(base, NW);
        restore_state = 1'b1;
        n = 0;
        do begin
            tick(); n++;
        end while (ack_to_ctrl !== 1'b1 && n < 30);
        chk({tag, "_ack_lat"}, 64'(n - 1), 64'(NW + 1));
        chk({tag, "_wr_left"}, 64'(exp_q.size()), 64'd0);
        chk({tag, "_cg"}, 64'(clk_gate_en), 64'd1);
        restore_state = 1'b0;
        tick();
        chk({tag, "_ack_drop"}, 64'(ack_to_ctrl), 64'd0);
        chk({tag, "_state"}, 64'(dut.r_state), 64'(IDLE));
    endtask

    initial begin
        int n;
        int acks;

        // ---- reset values ----
        do_reset();
        chk_reset_vals("reset");

        // ---- restore from reset: no snapshot, ack without writes ----
        restore_state = 1'b1;
        tick();
        chk("rst_restore_ack", 64'(ack_to_ctrl), 64'd1);
        chk("rst_restore_err", 64'(retention_err), 64'd1);
        tick();
        chk("rst_restore_ack_hold", 64'(ack_to_ctrl), 64'd1);
        restore_state = 1'b0;
        tick();
        chk("rst_restore_ack_drop", 64'(ack_to_ctrl), 64'd0);
        chk("rst_restore_state", 64'(dut.r_state), 64'(IDLE));
        chk("rst_restore_err_sticky", 64'(retention_err), 64'd1);

        // ---- save then restore, pattern A0.. ----
        do_reset();
        do_save(32'hA0, "saveA");
        do_restore(32'hA0, "restA");
        chk("restA_err", 64'(retention_err), 64'd0);

        // ---- restore in IDLE with snapshot: ack, no writes ----
        restore_state = 1'b1;
        tick();
        chk("idle_restore_ack", 64'(ack_to_ctrl), 64'd1);
        chk("idle_restore_err", 64'(retention_err), 64'd0);
        restore_state = 1'b0;
        tick();
        chk("idle_restore_ack_drop", 64'(ack_to_ctrl), 64'd0);

        // ---- save held off by block_busy ----
        fill_live(32'hB0);
        block_busy = 1'b1;
        save_state = 1'b1;
        repeat (5) tick();
        chk("busy_state", 64'(dut.r_state), 64'(WAIT_IDLE));
        chk("busy_cg", 64'(clk_gate_en), 64'd0);
        chk("busy_ack", 64'(ack_to_ctrl), 64'd0);
        block_busy = 1'b0;
        n = 0;
        do begin
            tick(); n++;
        end while (ack_to_ctrl !== 1'b1 && n < 30);
        chk("busy_ack_lat", 64'(n), 64'(NW + 2));
        save_state = 1'b0;
        tick();
        tick();

        // ---- both requests in RETAINED: error, no movement ----
        save_state = 1'b1;
        restore_state = 1'b1;
        tick(); tick();
        chk("both_err", 64'(retention_err), 64'd1);
        chk("both_state", 64'(dut.r_state), 64'(RETAINED));
        chk("both_ack", 64'(ack_to_ctrl), 64'd0);
        save_state = 1'b0;
        do_restore(32'hB0, "restB");

        // ---- power drop during SAVE word 3 ----
        do_reset();
        fill_live(32'hC0);
        save_state = 1'b1;
        repeat (5) tick();
        chk("sabort_rdidx", 64'(live_rd_idx), 64'd3);
        power_switch_en = 1'b0;
        tick();
        chk("sabort_sv", 64'(saved_valid), 64'd0);
        chk("sabort_err", 64'(retention_err), 64'd1);
        chk("sabort_state", 64'(dut.r_state), 64'(RETAINED));
        chk("sabort_cg", 64'(clk_gate_en), 64'd0);
        acks = 0;
        repeat (12) begin
            tick();
            if (ack_to_ctrl !== 1'b0) acks++;
        end
        chk("sabort_no_ack", 64'(acks), 64'd0);
        save_state = 1'b0;
        power_switch_en = 1'b1;
        tick();

        // ---- power drop during RESTORE word 2, then retry ----
        do_reset();
        do_save(32'hD0, "saveD");
        push_restore(32'hD0, 3);
        restore_state = 1'b1;
        repeat (3) tick();
        power_switch_en = 1'b0;
        tick();
        chk("rabort_wren", 64'(live_wr_en), 64'd0);
        chk("rabort_err", 64'(retention_err), 64'd1);
        chk("rabort_state", 64'(dut.r_state), 64'(RETAINED));
        chk("rabort_sv", 64'(saved_valid), 64'd1);
        chk("rabort_wr_left", 64'(exp_q.size()), 64'd0);
        tick();
        power_switch_en = 1'b1;
        do_restore(32'hD0, "retryD");

        // ---- reset at RESTORE word 4 ----
        do_reset();
        do_save(32'hE0, "saveE");
        push_restore(32'hE0, NW);
        restore_state = 1'b1;
        repeat (5) tick();
        chk("rrst_word4_idx", 64'(live_wr_idx), 64'd4);
        rst = 1'b1;
        tick();
        exp_q.delete();
        chk_reset_vals("rrst");
        rst = 1'b0;
        restore_state = 1'b0;
        repeat (4) tick();
        chk("rrst_after_state", 64'(dut.r_state), 64'(IDLE));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
